// File: rtl/spi_peripheral_pkg.sv
// spi_peripheral_pkg: shared FSM states, frame width and register map for the SPI config target
package spi_peripheral_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  localparam int FRAME_BITS = 16;
  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;
endpackage

// File: rtl/spi_peripheral_if.sv
// spi_peripheral_if: SPI pin bundle; master drives sclk/copi/ncs, slave drives cipo
interface spi_peripheral_if;
  logic sclk;
  logic copi;
  logic ncs;
  logic cipo;
  modport master (output sclk, output copi, output ncs, input cipo);
  modport slave (input sclk, input copi, input ncs, output cipo);
endinterface

// File: rtl/spi_peripheral_sync_edge_detect.sv
// sync_edge_detect: multi-flop synchroniser with one history flop giving level, rise and fall
module sync_edge_detect #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  // shift the async pin through the synchroniser and remember the previous synchronised level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end
  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~hist_q;
  assign fall_o  = ~level_o & hist_q;
endmodule

// File: rtl/spi_peripheral.sv
// spi_peripheral: SPI mode-0 target holding five 8-bit PWM config registers; SPI_READBACK_EN adds cipo readback
module spi_peripheral
  import spi_peripheral_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic              clk,
  input  logic              rst,
  spi_peripheral_if.slave   spi,
  output logic [7:0]        en_reg_out_7_0,
  output logic [7:0]        en_reg_out_15_8,
  output logic [7:0]        en_reg_pwm_7_0,
  output logic [7:0]        en_reg_pwm_15_8,
  output logic [7:0]        pwm_duty_cycle
);
  logic       sclk_lvl, sclk_rise, sclk_fall;
  logic       ncs_lvl, ncs_rise, ncs_fall;
  logic       copi_lvl, copi_rise, copi_fall;
  logic       unused_ok;
  state_t     state_q;
  logic [4:0] cnt_q;
  logic [15:0] shreg_q;
  logic [7:0] regs_q [5];
  logic [6:0] addr;
  logic       wr_ok;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .d_i(spi.sclk), .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs (
    .clk(clk), .rst(rst), .d_i(spi.ncs), .level_o(ncs_lvl), .rise_o(ncs_rise), .fall_o(ncs_fall)
  );
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_copi (
    .clk(clk), .rst(rst), .d_i(spi.copi), .level_o(copi_lvl), .rise_o(copi_rise), .fall_o(copi_fall)
  );

  assign unused_ok = &{1'b0, sclk_lvl, sclk_fall, ncs_lvl, copi_rise, copi_fall};
  assign addr  = shreg_q[14:8];
  assign wr_ok = shreg_q[15] && addr <= MAX_ADDR && addr <= ADDR_DUTY;

  // frame FSM: ncs edge frames a transfer, sclk rises shift copi in, a full 16-bit write commits one register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      for (int i = 0; i < 5; i++) regs_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: if (ncs_fall) begin
          state_q <= SHIFT;
          cnt_q   <= '0;
          shreg_q <= '0;
        end
        SHIFT: if (ncs_rise) begin
          state_q <= (cnt_q == 5'(FRAME_BITS)) ? COMMIT : IDLE;
        end else if (sclk_rise) begin
          shreg_q <= {shreg_q[14:0], copi_lvl};
          cnt_q   <= (cnt_q == 5'(FRAME_BITS + 1)) ? cnt_q : cnt_q + 5'd1;
        end
        COMMIT: begin
          if (wr_ok) regs_q[addr[2:0]] <= shreg_q[7:0];
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign en_reg_out_7_0  = regs_q[ADDR_EN_OUT_LO[2:0]];
  assign en_reg_out_15_8 = regs_q[ADDR_EN_OUT_HI[2:0]];
  assign en_reg_pwm_7_0  = regs_q[ADDR_EN_PWM_LO[2:0]];
  assign en_reg_pwm_15_8 = regs_q[ADDR_EN_PWM_HI[2:0]];
  assign pwm_duty_cycle  = regs_q[ADDR_DUTY[2:0]];

`ifdef SPI_READBACK_EN
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] tx_q;
  logic       cipo_q;
  logic       rd_load;
  logic       tx_shift;
  assign rd_addr  = {shreg_q[5:0], copi_lvl};
  assign rd_data  = (!shreg_q[6] && rd_addr <= MAX_ADDR && rd_addr <= ADDR_DUTY) ? regs_q[rd_addr[2:0]] : 8'h00;
  assign rd_load  = state_q == SHIFT && !ncs_rise && sclk_rise && cnt_q == 5'd7;
  assign tx_shift = state_q == SHIFT && !ncs_rise && sclk_fall && cnt_q >= 5'd8 && cnt_q < 5'(FRAME_BITS);
  // load the addressed register after the header byte, then present it MSB first after each sclk fall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q   <= '0;
      cipo_q <= 1'b0;
    end else begin
      tx_q   <= rd_load ? rd_data : tx_shift ? {tx_q[6:0], 1'b0} : tx_q;
      cipo_q <= (state_q != SHIFT || ncs_rise) ? 1'b0 : tx_shift ? tx_q[7] : cipo_q;
    end
  end
  assign spi.cipo = cipo_q;
`else
  assign spi.cipo = 1'b0;
`endif
endmodule

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral: scoreboard bench driving SPI frames and checking register/cipo results
module tb_spi_peripheral;
  import spi_peripheral_pkg::*;
  typedef struct packed {
    logic [39:0] regs;
    logic [7:0]  rx;
    logic        chk_rx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  r0, r1, r2, r3, r4;
  logic [39:0] regs_now;
  logic [7:0]  model [5];
  exp_t        sb [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  spi_peripheral_if spi ();

  spi_peripheral dut (
    .clk(clk), .rst(rst), .spi(spi),
    .en_reg_out_7_0(r0), .en_reg_out_15_8(r1), .en_reg_pwm_7_0(r2),
    .en_reg_pwm_15_8(r3), .pwm_duty_cycle(r4)
  );

  always #5 clk = ~clk;
  assign regs_now = {r4, r3, r2, r1, r0};

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] mpack();
    return {model[4], model[3], model[2], model[1], model[0]};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input string tag, input logic [16:0] bits, input int n, input int rst_after);
    logic [7:0]  rx;
    logic [39:0] old;
    logic [15:0] f;
    exp_t        e;
    rx  = 8'h00;
    old = mpack();
    f   = bits[15:0];
    e.rx = 8'h00;
`ifdef SPI_READBACK_EN
    if (!f[15] && f[14:8] <= 7'h04) e.rx = model[f[10:8]];
`endif
    spi.ncs = 1'b0;
    tick(4);
    for (int i = n - 1; i >= 0; i--) begin
      spi.copi = bits[i];
      tick(4);
      if (i < 8) rx = {rx[6:0], spi.cipo};
      spi.sclk = 1'b1;
      tick(4);
      spi.sclk = 1'b0;
      if (n - i == rst_after) begin
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) model[k] = 8'h00;
        old = mpack();
      end
    end
    spi.copi = 1'b0;
    tick(4);
    spi.ncs = 1'b1;
    if (n == 16 && rst_after < 0 && f[15] && f[14:8] <= 7'h04) model[f[10:8]] = f[7:0];
    e.regs   = mpack();
    e.chk_rx = n == 16 && rst_after < 0;
    sb.push_back(e);
    tick(3);
    chk({tag, "_hold"}, regs_now, old);
    tick(1);
    e = sb.pop_front();
    chk({tag, "_regs"}, regs_now, e.regs);
    chk({tag, "_cipo_idle"}, {39'd0, spi.cipo}, 40'd0);
    if (e.chk_rx) chk({tag, "_rx"}, {32'd0, rx}, {32'd0, e.rx});
    tick(6);
  endtask

  initial begin
    for (int k = 0; k < 5; k++) model[k] = 8'h00;
    spi.sclk = 1'b0;
    spi.copi = 1'b0;
    spi.ncs  = 1'b1;
    #1 rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      spi.sclk = 1'($urandom_range(0, 1));
      spi.copi = 1'($urandom_range(0, 1));
      spi.ncs  = 1'($urandom_range(0, 1));
      tick(1);
    end
    chk("rst_regs", regs_now, 40'd0);
    chk("rst_cipo", {39'd0, spi.cipo}, 40'd0);
    spi.sclk = 1'b0;
    spi.copi = 1'b0;
    spi.ncs  = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(10);
    chk("post_rst_regs", regs_now, 40'd0);
    chk("post_rst_cipo", {39'd0, spi.cipo}, 40'd0);
    frame("w00",      17'h080F0, 16, -1);
    frame("w02",      17'h08255, 16, -1);
    frame("w04",      17'h08480, 16, -1);
    frame("unmapped", 17'h085AA, 16, -1);
    frame("read00",   17'h000FF, 16, -1);
    frame("short15",  17'h040D5, 15, -1);
    frame("long17",   17'h10355, 17, -1);
    frame("w01",      17'h08133, 16, -1);
    frame("w03",      17'h0837E, 16, -1);
    frame("read03",   17'h00300, 16, -1);
    frame("midrst",   17'h083C3, 16, 10);
    frame("w04b",     17'h08480, 16, -1);
    frame("read04",   17'h00400, 16, -1);
    frame("read05",   17'h00500, 16, -1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
